// File: rtl/mcc_core.sv
// mcc_core: multi-cycle core with one unified req/ack memory port.
// Each instruction walks FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB).
// The sequence ends early for branches and HALT.
// All memory-port outputs, halted, pc and retired come straight from flops.
module mcc_core #(
  parameter int XLEN = 32,
  parameter int NREGS = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       retired
);

  localparam int SH_W = $clog2(XLEN);
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int MSB = XLEN - 1;
  localparam logic [4:0] NREGS_V = NREGS[4:0];
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BR   = 4'hA;
  localparam logic [3:0] OP_MOVI = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [31:0]       ir_r;
  logic [XLEN-1:0]   a_r, b_r, d_r, result_r;
  logic [XLEN-1:0]   regs_r [NREGS];
  logic              flag_z_r, flag_n_r, flag_c_r, flag_v_r;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [31:0]       retired_r;
  logic              mem_req_r, mem_we_r, halted_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [XLEN-1:0]   mem_wdata_r;

  logic              req_nxt_s, we_nxt_s, halted_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [XLEN-1:0]   wdata_nxt_s;

  // An ack only counts while a request is actually outstanding.
  logic ack_s;
  assign ack_s = mem_ack & mem_req_r;

  // Instruction fields.
  logic [3:0]      op_s, rd_s, rs1_s, rs2_s;
  logic [15:0]     imm_s;
  logic [XLEN-1:0] simm_s, opb_s, ea_s;
  assign op_s   = ir_r[31:28];
  assign rd_s   = ir_r[27:24];
  assign rs1_s  = ir_r[23:20];
  assign rs2_s  = ir_r[19:16];
  assign imm_s  = ir_r[15:0];
  assign simm_s = {{(XLEN-16){imm_s[15]}}, imm_s};
  assign opb_s  = (op_s == OP_ADDI) ? simm_s : b_r;
  assign ea_s   = a_r + simm_s;

  // r0 and indices beyond the implemented file are hard zero / write-dropped.
  function automatic logic reg_ok(input logic [3:0] idx);
    reg_ok = (idx != 4'd0) && ({1'b0, idx} < NREGS_V);
  endfunction

  // Wide arithmetic so carry/borrow and the shifted-out bit fall out directly.
  logic [XLEN:0]   sum_s, dif_s, shl_s, shr_s;
  logic [SH_W-1:0] sh_s;
  assign sh_s  = b_r[SH_W-1:0];
  assign sum_s = {1'b0, a_r} + {1'b0, opb_s};
  assign dif_s = {1'b0, a_r} - {1'b0, b_r};
  assign shl_s = {1'b0, a_r} << sh_s;
  assign shr_s = {a_r, 1'b0} >> sh_s;

  logic [XLEN-1:0] alu_res_s;
  logic            alu_c_s, alu_v_s;

  // ALU result and flag candidates for the instruction in IR.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op_s)
      OP_ADD, OP_ADDI: begin
        alu_res_s = sum_s[XLEN-1:0];
        alu_c_s   = sum_s[XLEN];
        alu_v_s   = (a_r[MSB] == opb_s[MSB]) && (sum_s[MSB] != a_r[MSB]);
      end
      OP_SUB: begin
        alu_res_s = dif_s[XLEN-1:0];
        alu_c_s   = dif_s[XLEN];
        alu_v_s   = (a_r[MSB] != b_r[MSB]) && (dif_s[MSB] != a_r[MSB]);
      end
      OP_AND:  alu_res_s = a_r & b_r;
      OP_OR:   alu_res_s = a_r | b_r;
      OP_XOR:  alu_res_s = a_r ^ b_r;
      OP_SHL: begin
        alu_res_s = shl_s[XLEN-1:0];
        alu_c_s   = shl_s[XLEN];
      end
      OP_SHR: begin
        alu_res_s = shr_s[XLEN:1];
        alu_c_s   = shr_s[0];
      end
      OP_MOVI: alu_res_s = {{(XLEN-16){1'b0}}, imm_s};
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  logic taken_s;

  // Branch condition evaluation against the current flags.
  always_comb begin
    taken_s = 1'b0;
    case (rs2_s)
      4'h0:    taken_s = 1'b1;
      4'h1:    taken_s = flag_z_r;
      4'h2:    taken_s = ~flag_z_r;
      4'h3:    taken_s = flag_n_r;
      4'h4:    taken_s = flag_c_r;
      default: taken_s = 1'b0;
    endcase
  end

  // Next PC: only branches, acked stores and write-back move it.
  always_comb begin
    pc_nxt_s = pc_r;
    case (state_r)
      S_EXECUTE: begin
        if (op_s == OP_BR) begin
          pc_nxt_s = taken_s ? (pc_r + simm_s[ADDR_W-1:0]) : (pc_r + PC_ONE);
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      S_MEM: begin
        if (ack_s && (op_s == OP_ST)) begin
          pc_nxt_s = pc_r + PC_ONE;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      S_WB:    pc_nxt_s = pc_r + PC_ONE;
      default: pc_nxt_s = pc_r;
    endcase
  end

  logic retire_s, wb_en_s;
  assign retire_s = ((state_r == S_EXECUTE) && ((op_s == OP_BR) || (op_s == OP_HALT)))
                  || ((state_r == S_MEM) && ack_s && (op_s == OP_ST))
                  || (state_r == S_WB);
  assign wb_en_s  = (op_s <= OP_LD) || (op_s == OP_MOVI);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH:  state_nxt_s = ack_s ? S_DECODE : S_FETCH;
      S_DECODE: state_nxt_s = S_EXECUTE;
      S_EXECUTE: begin
        case (op_s)
          OP_LD, OP_ST: state_nxt_s = S_MEM;
          OP_BR:        state_nxt_s = S_FETCH;
          OP_HALT:      state_nxt_s = S_HALT;
          default:      state_nxt_s = S_WB;
        endcase
      end
      S_MEM: begin
        if (ack_s) begin
          state_nxt_s = (op_s == OP_ST) ? S_FETCH : S_WB;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB:    state_nxt_s = S_FETCH;
      S_HALT:  state_nxt_s = S_HALT;
      default: state_nxt_s = S_FETCH;
    endcase
  end

  // Output logic: port values for the state being entered. Waiting states recompute identical values.
  always_comb begin
    req_nxt_s    = 1'b0;
    we_nxt_s     = 1'b0;
    addr_nxt_s   = {ADDR_W{1'b0}};
    wdata_nxt_s  = {XLEN{1'b0}};
    halted_nxt_s = 1'b0;
    case (state_nxt_s)
      S_FETCH: begin
        req_nxt_s  = 1'b1;
        addr_nxt_s = pc_nxt_s;
      end
      S_MEM: begin
        req_nxt_s   = 1'b1;
        we_nxt_s    = (op_s == OP_ST);
        addr_nxt_s  = ea_s[ADDR_W-1:0];
        wdata_nxt_s = (op_s == OP_ST) ? d_r : {XLEN{1'b0}};
      end
      S_HALT:  halted_nxt_s = 1'b1;
      default: req_nxt_s = 1'b0;
    endcase
  end

  // Registered memory-port and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {XLEN{1'b0}};
      halted_r    <= 1'b0;
    end else begin
      mem_req_r   <= req_nxt_s;
      mem_we_r    <= we_nxt_s;
      mem_addr_r  <= addr_nxt_s;
      mem_wdata_r <= wdata_nxt_s;
      halted_r    <= halted_nxt_s;
    end
  end

  // Datapath: PC, retire counter, IR, operands, flags and register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r      <= RESET_PC;
      retired_r <= 32'd0;
      ir_r      <= 32'd0;
      a_r       <= {XLEN{1'b0}};
      b_r       <= {XLEN{1'b0}};
      d_r       <= {XLEN{1'b0}};
      result_r  <= {XLEN{1'b0}};
      flag_z_r  <= 1'b0;
      flag_n_r  <= 1'b0;
      flag_c_r  <= 1'b0;
      flag_v_r  <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      pc_r <= pc_nxt_s;
      if (retire_s) begin
        retired_r <= retired_r + 32'd1;
      end
      case (state_r)
        S_FETCH: begin
          if (ack_s) begin
            ir_r <= mem_rdata[31:0];
          end
        end
        S_DECODE: begin
          a_r <= reg_ok(rs1_s) ? regs_r[rs1_s[IDX_W-1:0]] : {XLEN{1'b0}};
          b_r <= reg_ok(rs2_s) ? regs_r[rs2_s[IDX_W-1:0]] : {XLEN{1'b0}};
          d_r <= reg_ok(rd_s)  ? regs_r[rd_s[IDX_W-1:0]]  : {XLEN{1'b0}};
        end
        S_EXECUTE: begin
          result_r <= alu_res_s;
          if (op_s <= OP_ADDI) begin
            flag_z_r <= (alu_res_s == {XLEN{1'b0}});
            flag_n_r <= alu_res_s[MSB];
            flag_c_r <= alu_c_s;
            flag_v_r <= alu_v_s;
          end
        end
        S_MEM: begin
          if (ack_s && (op_s == OP_LD)) begin
            result_r <= mem_rdata;
          end
        end
        S_WB: begin
          if (wb_en_s && reg_ok(rd_s)) begin
            regs_r[rd_s[IDX_W-1:0]] <= result_r;
          end
        end
        default: ;
      endcase
    end
  end

  // V is maintained as architectural state; no cond code currently reads it.
  logic unused_v_s;
  assign unused_v_s = flag_v_r;

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign halted    = halted_r;
  assign pc        = pc_r;
  assign retired   = retired_r;

endmodule

// File: doc/mcc_core.md
Name: mcc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle core.
- Executes one instruction at a time through a FETCH/DECODE/EXECUTE/MEM/WB state machine.
- Uses a single unified memory port with a req/ack handshake, so it tolerates wait-state memories.
- Data width and register-file depth are parameters; it adds a retired-instruction counter.

Parameters:
- XLEN, 32, datapath/register width; legal values ≥32. Instructions occupy mem_rdata[31:0].
- NREGS, 16, implemented registers, 2..16. r0 reads as zero.
- ADDR_W, 16, word-address width of the memory port and the PC.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  one-cycle acknowledge; may arrive in the same cycle as mem_req.
- halted  out  1  high once a HALT instruction retires.
- pc  out  ADDR_W  address of the instruction currently executing.
- retired  out  32  count of retired instructions, wraps at 2^32.

Behaviour:
- Reset (rst=0, acts asynchronously):
  - State=FETCH; pc=RESET_PC.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, retired=0.
  - Registers and flags {Z,N,C,V} cleared.
  - Reset during an outstanding request drops mem_req immediately. An ack arriving during or after reset is ignored.
- Instruction format:
  - [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2/cond, [15:0] imm.
  - simm = sign-extended imm (XLEN bits). Register indices ≥NREGS read 0; writes to them are dropped.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: rd = rs1 op rs2.
  - 5 SHL, 6 SHR (logical): rd = rs1 shifted by rs2[$clog2(XLEN)-1:0].
  - 7 ADDI: rd = rs1 + simm.
  - 8 LD: rd = mem[rs1+simm].
  - 9 ST: mem[rs1+simm] = rd.
  - A BR: if cond holds, pc = pc + simm, else pc+1. Cond codes: 0 always, 1 Z, 2 !Z, 3 N, 4 C; 5..F never.
  - B MOVI: rd = zero-extended imm.
  - F HALT.
  - C..E: NOP (retired, no other effect).
- Flags:
  - Updated by ops 0..7 only.
  - Z = result==0; N = result[XLEN-1].
  - C = carry-out for ADD/ADDI, borrow for SUB, last bit shifted out for shifts, 0 for logic ops.
  - V = signed overflow for add/sub, else 0.
- Memory address: addresses are the low ADDR_W bits of the computed value (wraps).
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack, latch mem_rdata[31:0] into IR and go to DECODE.
  - DECODE: read rs1/rs2/rd, go to EXECUTE.
  - EXECUTE: ALU or address calculation.
    - LD/ST go to MEM.
    - BR updates pc, increments retired, and goes to FETCH.
    - HALT goes to HALT and increments retired.
    - All other ops go to WB.
  - MEM: mem_req=1; mem_we=1 for ST. On ack: ST retires and goes to FETCH; LD latches data and goes to WB.
  - WB: write rd (dropped for r0), pc=pc+1 (wraps), retired++, go to FETCH.
  - HALT: halted=1, mem_req=0. Held until reset.
- Handshake: mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and ack=0. mem_req deasserts the cycle after ack unless the next state also requests. Acks received while mem_req=0 are ignored.
- Cycle counts with zero-wait memory (ack in the request cycle):
  - ALU/MOVI/NOP: 4 cycles.
  - BR: 3 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Reset: hold rst=0 with RESET_PC=0x10, release → first mem_req=1 with mem_addr=0x10. All outputs were 0 during reset.
- ALU/flags: MOVI r1,0xFFFF; ADDI r2,r1,1 (XLEN=32) → r2=0x10000, Z=0, C=0. Then SUB r3,r1,r1 → r3=0, Z=1, C=0. retired=3 after 12 cycles with zero-wait memory.
- Load/store with 3 wait states per access: ST r2→[r0+0x20], LD r4←[0x20] → write seen at addr 0x20 with wdata=0x10000, and r4=0x10000. Every request holds its address and data stable during the waits.
- Branch: Z=1, BR cond=1, imm=-2 at pc=0x05 → next fetch at addr 0x03. With cond=2 instead → next fetch at 0x06. Branch at pc=0 with imm=-1 → fetch at 2^ADDR_W-1.
- Reset mid-MEM: assert rst while ST has mem_req=1 and ack=0 → mem_req falls without waiting for a clock, no write is retired, and the core refetches from RESET_PC.
- HALT and parameters (NREGS=8, XLEN=64): writing r12 is dropped and reading it gives 0. HALT → halted=1 and no further mem_req. A late stray ack is ignored and retired does not change.
